// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks a 16-bit program counter through instruction memory,
// latches each returned word into the IR and hands it to the opcode decoder.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        ir_consume,
    input  logic        pc_load,
    input  logic [15:0] pc_in,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] ir,
    output logic [7:0]  opcode,
    output logic        dec_en,
    output logic [15:0] instr_pc,
    output logic        fetch_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_t;

    // The counter holds completed waiting cycles, so the last allowed REQ cycle sees TIMEOUT-1.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [15:0] pc_ptr, pc_nx;
    logic [15:0] pend_pc, pend_pc_nx;
    logic        pend_valid, pend_valid_nx;
    logic [7:0]  wait_cnt, wait_cnt_nx;
    logic [15:0] ir_nx, instr_pc_nx;
    logic        dec_en_nx, fetch_err_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_ptr     <= RESET_PC;
            pend_pc    <= 16'h0000;
            pend_valid <= 1'b0;
            wait_cnt   <= 8'h00;
            ir         <= 16'h0000;
            instr_pc   <= 16'h0000;
            dec_en     <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            pc_ptr     <= pc_nx;
            pend_pc    <= pend_pc_nx;
            pend_valid <= pend_valid_nx;
            wait_cnt   <= wait_cnt_nx;
            ir         <= ir_nx;
            instr_pc   <= instr_pc_nx;
            dec_en     <= dec_en_nx;
            fetch_err  <= fetch_err_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        pc_nx         = pc_ptr;
        pend_pc_nx    = pend_pc;
        pend_valid_nx = pend_valid;
        wait_cnt_nx   = wait_cnt;
        ir_nx         = ir;
        instr_pc_nx   = instr_pc;
        dec_en_nx     = dec_en;
        fetch_err_nx  = 1'b0;

        case (state)
            IDLE: begin
                wait_cnt_nx = 8'h00;
                if (pc_load) pc_nx = pc_in;
                if (fetch_req) state_nx = REQ;
            end
            REQ: begin
                // A redirect on the exit cycle is the newest target and beats any pending one.
                if (mem_ack) begin
                    ir_nx         = mem_rdata;
                    instr_pc_nx   = pc_ptr;
                    dec_en_nx     = 1'b1;
                    state_nx      = HOLD;
                    wait_cnt_nx   = 8'h00;
                    pend_valid_nx = 1'b0;
                    if (pc_load)         pc_nx = pc_in;
                    else if (pend_valid) pc_nx = pend_pc;
                    else                 pc_nx = pc_ptr + 16'd1;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_nx      = IDLE;
                    fetch_err_nx  = 1'b1;
                    wait_cnt_nx   = 8'h00;
                    pend_valid_nx = 1'b0;
                    if (pc_load)         pc_nx = pc_in;
                    else if (pend_valid) pc_nx = pend_pc;
                end else begin
                    wait_cnt_nx = wait_cnt + 8'd1;
                    if (pc_load) begin
                        pend_valid_nx = 1'b1;
                        pend_pc_nx    = pc_in;
                    end
                end
            end
            HOLD: begin
                if (pc_load) pc_nx = pc_in;
                if (ir_consume && dec_en) begin
                    dec_en_nx = 1'b0;
                    state_nx  = fetch_req ? REQ : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign opcode   = ir[15:8];
    assign busy     = (state == REQ);
    assign mem_rd   = (state == REQ);
    assign mem_addr = pc_ptr;

endmodule
